// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory stage of an RV32I pipeline. Takes the execute-stage ALU result as an
// effective address and performs one load or store per request on the data
// memory bus. It handles byte/halfword lane placement, store strobes, load
// sign/zero extension, misaligned/illegal detection and a bus timeout.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready execute-side handshake (ready only when idle)
//   req_write           1 = store, 0 = load
//   req_funct3          RV32I funct3 of the memory op
//   req_addr            effective address
//   req_wdata           store data (rs2)
//   mem_valid/mem_ready data-memory request / completion
//   mem_write           bus write enable
//   mem_addr            word-aligned bus address
//   mem_wdata           lane-replicated store data
//   mem_wstrb           byte strobes (0 on loads)
//   mem_rdata           read word, valid with mem_ready
//   resp_valid          one-cycle result pulse to writeback
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_error          00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] E_OK      = 2'b00;
  localparam logic [1:0] E_MISALGN = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;
  localparam logic [1:0] E_ILLEGAL = 2'b11;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_mem_valid;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_error;

  logic        w_illegal;
  logic        w_misaligned;

  // Loads accept 000/001/010/100/101; stores accept only 000/001/010.
  function automatic logic f_illegal(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 >= 3'b011);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // f3[1:0] encodes size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the data across lanes lets the strobe alone select the target.
  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return rd;
    endcase
  endfunction

  assign w_illegal    = f_illegal(req_write, req_funct3);
  assign w_misaligned = f_misaligned(req_funct3, req_addr[1:0]);

  // Combinational so that it reads 1 while reset holds the FSM in IDLE.
  assign req_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= E_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            if (w_illegal) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_error <= E_ILLEGAL;
            end else if (w_misaligned) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_error <= E_MISALGN;
            end else begin
              r_state     <= S_MEM;
              r_mem_valid <= 1'b1;
              r_mem_write <= req_write;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_wdata <= req_write ? f_wdata(req_funct3, req_wdata) : '0;
              r_mem_wstrb <= req_write ? f_wstrb(req_funct3, req_addr[1:0]) : 4'b0000;
            end
          end
        end
        S_MEM: begin
          // Completion is checked first so a ready in the final cycle wins.
          if (mem_ready) begin
            r_state      <= S_RESP;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_mem_write ? '0 : f_load(r_funct3, r_off, mem_rdata);
            r_resp_error <= E_OK;
          end else if (r_cnt == TO_LAST) begin
            r_state      <= S_RESP;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_error <= E_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_cnt        <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_valid  = r_mem_valid;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request in an IDLE cycle; returns #1 after the accepting edge.
  task automatic issue(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s req_ready before issue: got %b want 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = data;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    checks++;
    if ({mem_valid, mem_write, mem_wstrb} !== 6'b0) begin
      failures++; $display("FAIL reset mem ctrl: got %b want 000000", {mem_valid, mem_write, mem_wstrb});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'b0) begin
      failures++; $display("FAIL reset mem addr/wdata: got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({resp_valid, resp_error, resp_rdata} !== 35'b0) begin
      failures++; $display("FAIL reset resp: got v=%b e=%b d=%h want 0", resp_valid, resp_error, resp_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // A legal access that reaches the bus; ready arrives after `waits` idle cycles.
  task automatic test_access(input string name, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int waits, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input logic [31:0] exp_rdata);
    issue(name, wr, f3, addr, wdata);
    checks++;
    if (mem_valid !== 1'b1 || mem_write !== wr) begin
      failures++; $display("FAIL %s bus start: got valid=%b write=%b want 1/%b", name, mem_valid, mem_write, wr);
    end
    checks++;
    if (mem_addr !== exp_addr) begin
      failures++; $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, exp_addr);
    end
    checks++;
    if (mem_wstrb !== exp_wstrb) begin
      failures++; $display("FAIL %s mem_wstrb: got %b want %b", name, mem_wstrb, exp_wstrb);
    end
    if (wr) begin
      checks++;
      if (mem_wdata !== exp_wdata) begin
        failures++; $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata, exp_wdata);
      end
    end
    for (int i = 0; i < waits; i++) begin
      mem_rdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      checks++;
      if (mem_valid !== 1'b1 || resp_valid !== 1'b0 || mem_addr !== exp_addr || mem_wstrb !== exp_wstrb) begin
        failures++;
        $display("FAIL %s wait%0d hold: got valid=%b resp=%b addr=%h strb=%b want 1/0/%h/%b",
                 name, i, mem_valid, resp_valid, mem_addr, mem_wstrb, exp_addr, exp_wstrb);
      end
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    checks++;
    if (resp_valid !== 1'b1 || mem_valid !== 1'b0) begin
      failures++; $display("FAIL %s resp timing: got resp=%b mem_valid=%b want 1/0", name, resp_valid, mem_valid);
    end
    checks++;
    if (resp_rdata !== exp_rdata || resp_error !== 2'b00) begin
      failures++; $display("FAIL %s resp data: got %h err=%b want %h err=00", name, resp_rdata, resp_error, exp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s return idle: got resp=%b ready=%b want 0/1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_error(input string name, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [1:0] exp_err);
    mem_ready = 1'b1;  // must be ignored outside MEM
    issue(name, wr, f3, addr, 32'hFFFF_FFFF);
    checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b1) begin
      failures++; $display("FAIL %s err timing: got mem_valid=%b resp=%b want 0/1", name, mem_valid, resp_valid);
    end
    checks++;
    if (resp_error !== exp_err || resp_rdata !== 32'h0) begin
      failures++; $display("FAIL %s err value: got err=%b d=%h want err=%b d=0", name, resp_error, resp_rdata, exp_err);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL %s err idle: got resp=%b mem_valid=%b ready=%b want 0/0/1", name, resp_valid, mem_valid, req_ready);
    end
  endtask

  task automatic test_timeout();
    issue("timeout", 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_valid !== 1'b1 || resp_valid !== 1'b0) begin
        failures++; $display("FAIL timeout cycle%0d: got mem_valid=%b resp=%b want 1/0", i, mem_valid, resp_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b1 || resp_error !== 2'b10 || resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout resp: got mem_valid=%b resp=%b err=%b d=%h want 0/1/10/0",
               mem_valid, resp_valid, resp_error, resp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL timeout idle: got resp=%b ready=%b want 0/1", resp_valid, req_ready);
    end
    // Ready arriving in the last permitted cycle completes normally.
    test_access("timeout_last_ready", 1'b0, 3'b010, 32'h0000_0404, 32'h0, 3, 32'h1122_3344,
                32'h0000_0404, 32'h0, 4'b0000, 32'h1122_3344);
  endtask

  task automatic test_reset_mid();
    issue("reset_mid", 1'b1, 3'b010, 32'h0000_0500, 32'h5555_AAAA);
    checks++;
    if (mem_valid !== 1'b1) begin
      failures++; $display("FAIL reset_mid start: got mem_valid=%b want 1", mem_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid async: got mem_valid=%b resp=%b ready=%b want 0/0/1", mem_valid, resp_valid, req_ready);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid after: got resp=%b mem_valid=%b ready=%b want 0/0/1", resp_valid, mem_valid, req_ready);
    end
    test_access("reset_mid_sw", 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF,
                32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;

    test_reset();
    //          name     wr    f3      addr          wdata         waits rdata         exp_addr      exp_wdata     strb     exp_rdata
    test_access("lw",    1'b0, 3'b010, 32'h0000_0100, 32'h0,        2, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF);
    test_access("lb",    1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80);
    test_access("lbu",   1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0080);
    test_access("lhu",   1'b0, 3'b101, 32'h0000_0102, 32'h0,        1, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_80FF);
    test_access("lh",    1'b0, 3'b001, 32'h0000_0102, 32'h0,        0, 32'h80FF_0000, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_80FF);
    test_access("lb_lo", 1'b0, 3'b000, 32'h0000_0101, 32'h0,        0, 32'h0000_7F00, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_007F);
    test_access("sb",    1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 0, 32'hFFFF_FFFF, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010, 32'h0);
    test_access("sh",    1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 1, 32'h0,        32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, 32'h0);
    test_access("sw",    1'b1, 3'b010, 32'h0000_0208, 32'h0102_0304, 0, 32'h0,        32'h0000_0208, 32'h0102_0304, 4'b1111, 32'h0);

    test_error("lw_misaligned", 1'b0, 3'b010, 32'h0000_0102, 2'b01);
    test_error("sh_misaligned", 1'b1, 3'b001, 32'h0000_0103, 2'b01);
    test_error("ld_illegal",    1'b0, 3'b011, 32'h0000_0100, 2'b11);
    test_error("st_illegal",    1'b1, 3'b100, 32'h0000_0100, 2'b11);

    test_timeout();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory stage that consumes the execute-stage ALU result as an effective address and performs one RV32I load or store per request. It handles byte and halfword lane alignment, store strobe generation, and load sign/zero extension. It also detects misaligned and illegal accesses and enforces a bus timeout. It sits between execute and writeback and is the sole master on the data-memory request/response bus.

Parameters:
TIMEOUT, 255, max cycles mem_valid may stay high without mem_ready before the access is aborted (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  execute presents a memory op
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  effective address from the ALU result
req_wdata  input  32  store data (rs2)
mem_valid  output  1  bus request active
mem_write  output  1  bus write enable
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte strobes; 0 on loads
mem_ready  input  1  bus completes the access this cycle
mem_rdata  input  32  read word, valid when mem_ready
resp_valid  output  1  one-cycle result pulse to writeback
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3

Behaviour:
- Reset (async, rst_n low): state=IDLE; mem_valid, mem_write, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_error, timeout counter all 0.
- req_ready = (state==IDLE); it is combinational, so it reads 1 during reset.
- Reset mid-transaction aborts the access: mem_valid drops immediately and no response is produced.
- FSM states: IDLE, MEM, RESP.
- IDLE: on req_valid&&req_ready, latch all req_* fields.
  - Illegal funct3: loads 011/110/111, stores >=011. Go to RESP with error 11.
  - Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0. Go to RESP with error 01.
  - Otherwise go to MEM.
  - No bus traffic occurs for either error case.
- MEM: mem_valid=1. mem_addr, mem_write, mem_wdata and mem_wstrb stay stable until the state is left.
  - On mem_ready: capture mem_rdata, go to RESP with error 00.
  - Else the counter increments. When counter==TIMEOUT-1 and mem_ready is still low, mem_valid drops next cycle and the FSM goes to RESP with error 10.
  - mem_ready in that same final cycle wins: the access completes with error 00.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. The counter clears. resp_valid is 0 in all other states.
- Latency: accept at cycle N -> mem_valid at N+1. mem_ready at cycle M -> resp_valid at M+1. Error cases: resp_valid at N+1. Minimum throughput is one op per 3 cycles.
- Store lane rules (o = addr[1:0]):
  - SB: wdata={4{b[7:0]}}, wstrb=4'b0001<<o.
  - SH: wdata={2{b[15:0]}}, wstrb=4'b0011<<o.
  - SW: wdata=b, wstrb=4'b1111.
- Load extraction: byte = rdata[8*o+:8], half = rdata[16*o[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Store resp_rdata=0.
- mem_ready or mem_rdata outside MEM is ignored. req_valid outside IDLE is not accepted; execute must hold the request.

Test Plan:
- Reset then LW addr=0x100, mem_ready after 2 wait cycles, rdata=0xDEADBEEF -> mem_addr=0x100, wstrb=0, resp_rdata=0xDEADBEEF, error 00, resp_valid 1 cycle after mem_ready.
- LB addr=0x103 with rdata=0x80FF0000 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF; LH addr=0x102 -> 0xFFFF80FF.
- SB addr=0x201 data=0x123456AB -> mem_addr=0x200, wdata=0xABABABAB, wstrb=0010; SH addr=0x202 data=0xBEEF -> wstrb=1100, wdata=0xBEEFBEEF.
- LW addr=0x102, SH addr=0x103, and load funct3=011 -> no mem_valid, resp_valid next cycle with error 01, 01, 11 respectively, resp_rdata=0.
- TIMEOUT=4, mem_ready held low -> mem_valid high exactly 4 cycles, then resp error 10; second run with mem_ready in the 4th cycle -> error 00.
- Assert rst_n low while in MEM -> mem_valid 0 asynchronously, no resp_valid; after release req_ready=1 and a new SW completes normally.
